// File: rtl/tdr_scan_sequencer.sv
// tdr_scan_sequencer: sequences capture/shift/update of one TDR scan chain and collects TDO into a readback word.
module tdr_scan_sequencer #(
  parameter int LEN = 128,
  localparam int CW = $clog2(LEN)
) (
  input  logic           tck,
  input  logic           reset,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic           abort,
  input  logic [LEN-1:0] data_in,
  output logic [LEN-1:0] data_out,
  output logic           busy,
  output logic           done,
  output logic           aborted,
  output logic           shift_en,
  output logic           capture_en,
  output logic           update_en,
  output logic           tdi,
  input  logic           tdo
);
  typedef enum logic [2:0] {IDLE, CAPTURE, SHIFT, UPDATE, DONE} state_t;
  state_t         state, state_n;
  logic [LEN-1:0] tx, rx, rx_n;
  logic [CW-1:0]  cnt;
  logic           upd_q, accept, abort_hit;
  assign accept    = (state == IDLE) && start && !abort;
  assign abort_hit = abort && (state inside {CAPTURE, SHIFT, UPDATE});
  assign rx_n      = {rx[LEN-2:0], tdo};
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = accept ? (op[0] ? CAPTURE : SHIFT) : IDLE;
      CAPTURE: state_n = abort ? IDLE : SHIFT;
      SHIFT:   state_n = abort ? IDLE : (cnt == CW'(LEN-1)) ? (upd_q ? UPDATE : DONE) : SHIFT;
      UPDATE:  state_n = abort ? IDLE : DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  assign busy       = state != IDLE;
  assign done       = state == DONE;
  assign shift_en   = state == SHIFT;
  assign capture_en = state == CAPTURE;
  assign update_en  = state == UPDATE;
  assign tdi        = shift_en & tx[LEN-1];
  always_ff @(posedge tck) begin
    if (reset) begin
      state    <= IDLE;
      tx       <= '0;
      rx       <= '0;
      cnt      <= '0;
      upd_q    <= 1'b0;
      aborted  <= 1'b0;
      data_out <= '0;
    end else begin
      state   <= state_n;
      aborted <= abort_hit;
      cnt     <= shift_en ? cnt + CW'(1) : '0;
      if (accept) begin
        tx    <= data_in;
        upd_q <= op[1];
      end else if (shift_en) begin
        tx <= {tx[LEN-2:0], 1'b0};
      end
      if (shift_en) rx <= rx_n;
      // readback is published on entry to DONE so it is valid alongside the done pulse
      if (state_n == DONE && state != DONE) data_out <= shift_en ? rx_n : rx;
    end
  end
endmodule

// File: tb/tb_tdr_scan_sequencer.sv
// tb_tdr_scan_sequencer: randomized self-checking bench with a behavioural scan-chain model.
module tb_tdr_scan_sequencer;
  localparam int LEN = 128;
  logic           tck = 0, reset, start, abort, tdo;
  logic [1:0]     op;
  logic [LEN-1:0] data_in, data_out;
  logic           busy, done, aborted, shift_en, capture_en, update_en, tdi;
  logic [LEN-1:0] chain = '0, cap_val = '0, load_val = '0;
  logic           load_req = 0;
  int             n_chk = 0, n_fail = 0;

  tdr_scan_sequencer #(.LEN(LEN)) dut (
    .tck(tck), .reset(reset), .start(start), .op(op), .abort(abort),
    .data_in(data_in), .data_out(data_out), .busy(busy), .done(done),
    .aborted(aborted), .shift_en(shift_en), .capture_en(capture_en),
    .update_en(update_en), .tdi(tdi), .tdo(tdo)
  );

  always #5 tck = ~tck;

  assign tdo = chain[LEN-1];
  always @(posedge tck)
    if (load_req) chain <= load_val;
    else if (shift_en) chain <= {chain[LEN-2:0], tdi};
    else if (capture_en) chain <= cap_val;

  task automatic check(input string tag, input logic [LEN-1:0] got, input logic [LEN-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [LEN-1:0] v);
    load_val = v;
    load_req = 1;
    @(posedge tck); #1 load_req = 0;
  endtask

  function automatic logic [LEN-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Entry/exit: 1 time unit after a rising edge, DUT idle.
  task automatic run_op(input logic [1:0] o, input logic [LEN-1:0] din, input int abort_at);
    int dur, shifts, caps, upds, done_c, ab_c, tdi_err, viol, busy_err, k, exp_sh;
    logic fin;
    logic [LEN-1:0] exp_out, prev_do;
    dur = 1 + o[0] + LEN + o[1];
    shifts = 0; caps = 0; upds = 0; done_c = 0; ab_c = 0;
    tdi_err = 0; viol = 0; busy_err = 0; k = 0; fin = 0;
    exp_out = o[0] ? cap_val : chain;
    prev_do = data_out;
    start = 1; op = o; data_in = din;
    @(posedge tck); #1 start = 0;
    for (int c = 1; c < 400 && !fin; c++) begin
      abort = (c == abort_at);
      @(negedge tck);
      shifts += int'(shift_en); caps += int'(capture_en); upds += int'(update_en);
      if (int'(shift_en) + int'(capture_en) + int'(update_en) > 1 || (tdi && !shift_en)) viol++;
      if (shift_en) begin
        if (k < LEN && tdi !== din[LEN-1-k]) tdi_err++;
        k++;
      end
      if (!busy && !aborted) busy_err++;
      if (done) begin done_c = c; fin = 1; end
      if (aborted) begin ab_c = c; fin = 1; end
      @(posedge tck); #1;
    end
    abort = 0;
    if (!fin) check("timeout", 0, 1);
    check("enable_exclusive", viol, 0);
    if (abort_at == 0) begin
      check("done_cycle", done_c, dur);
      check("aborted_on_done", ab_c, 0);
      check("shift_cycles", shifts, LEN);
      check("capture_cycles", caps, o[0]);
      check("update_cycles", upds, o[1]);
      check("tdi_sequence", tdi_err, 0);
      check("busy_window", busy_err, 0);
      check("data_out", data_out, exp_out);
      check("chain_holds_din", chain, din);
    end else begin
      exp_sh = abort_at - o[0];
      exp_sh = exp_sh < 0 ? 0 : exp_sh > LEN ? LEN : exp_sh;
      check("aborted_cycle", ab_c, abort_at + 1);
      check("done_on_abort", done_c, 0);
      check("abort_shifts", shifts, exp_sh);
      check("abort_updates", upds, (o[1] && abort_at == dur - 1) ? 1 : 0);
      check("abort_data_out", data_out, prev_do);
      check("abort_idle", busy, 0);
    end
  endtask

  initial begin
    int upds, dones, dur, t, ab;
    int exp_q[$], got_q[$];
    logic [1:0] o;
    reset = 1; start = 0; abort = 0; op = 0; data_in = 0;
    repeat (2) @(posedge tck);
    @(negedge tck);
    check("reset_outputs", {busy, done, aborted, shift_en, capture_en, update_en, tdi}, 0);
    check("reset_data_out", data_out, 0);
    @(posedge tck); #1 reset = 0;

    preload(rnd128());
    run_op(2'b10, {4{32'hffff0000}}, 0);
    cap_val = 128'h0123456789abcdef_fedcba9876543210;
    run_op(2'b11, '0, 0);
    run_op(2'b00, 128'h1, 0);

    // reset while count==40 in a shift-then-update operation
    start = 1; op = 2'b10; data_in = rnd128();
    @(posedge tck); #1 start = 0;
    repeat (40) @(posedge tck);
    #1 reset = 1;
    @(posedge tck);
    @(negedge tck);
    check("midop_reset_outputs", {busy, done, aborted, shift_en, capture_en, update_en, tdi}, 0);
    check("midop_reset_data_out", data_out, 0);
    @(posedge tck); #1 reset = 0;
    upds = 0; dones = 0;
    repeat (200) begin
      @(negedge tck);
      upds += int'(update_en); dones += int'(done | busy);
    end
    check("no_update_after_reset", upds, 0);
    check("idle_after_reset", dones, 0);
    @(posedge tck); #1;

    run_op(2'b10, rnd128(), 64);
    run_op(2'b10, rnd128(), 129);
    run_op(2'b01, rnd128(), 1);

    start = 1; abort = 1; op = 2'b00; data_in = rnd128();
    @(posedge tck); #1 start = 0; abort = 0;
    @(negedge tck);
    check("start_abort_idle", {busy, aborted}, 0);
    @(posedge tck); #1;

    for (int i = 0; i < 12; i++) begin
      o = 2'($urandom_range(0, 3));
      dur = 1 + o[0] + LEN + o[1];
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, dur - 1) : 0;
      cap_val = rnd128();
      if ($urandom_range(0, 1) == 1) preload(rnd128());
      run_op(o, rnd128(), ab);
    end

    for (int r = 0; r < 2; r++) begin
      o = (r == 0) ? 2'b01 : 2'($urandom_range(0, 3));
      dur = 1 + o[0] + LEN + o[1];
      exp_q.delete(); got_q.delete();
      for (t = 0; t < 300; t += dur + 1) exp_q.push_back(t + dur);
      start = 1; op = o; data_in = rnd128();
      for (int c = 1; c <= 450; c++) begin
        @(posedge tck); #1 start = (c < 300);
        @(negedge tck);
        if (done) got_q.push_back(c);
      end
      check("b2b_count", got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) check("b2b_done_cycle", got_q[i], exp_q[i]);
      @(posedge tck); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
